// File: rtl/mdu_pkg.sv
// Shared op codes and FSM state type for the E-stage multiply/divide unit.
// The MADD family is only classified as multi-cycle when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_multi(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_multi = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
`endif
      default: is_multi = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_div32.sv
// Combinational 32-bit signed/unsigned divider; signed results truncate toward zero
// with the remainder taking the dividend's sign. Flags a zero divisor.
module mdu_div32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        dz
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  always_comb begin
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    dz    = (b == 32'd0);
    q_mag = dz ? 32'd0 : a_mag / b_mag;
    r_mag = dz ? 32'd0 : a_mag % b_mag;
    // 0x80000000 / -1 wraps back to 0x80000000 through the magnitude path.
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding HI/LO; results are computed at accept and
// committed after a modelled latency. MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
//
// state  | meaning
// S_IDLE | no op in flight; accepts multi-cycle ops, MTHI/MTLO, serves MFHI/MFLO
// S_RUN  | op in flight; counter counts down to commit, all other ops ignored
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_start,
  output logic        out_busy,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic [31:0] out_rdata
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_load;
  logic [31:0] hi_q, lo_q, res_hi_q, res_lo_q;
  logic        res_wr_q;

  logic        accept, mul_sgn, is_div, div_sgn, acc_add, acc_sub;
  logic [63:0] mul_a, mul_b, prod, sum;
  logic [31:0] quo, rem, res_hi_d, res_lo_d;
  logic        dz;

  mdu_div32 u_div (
    .a   (in_a),
    .b   (in_b),
    .sgn (div_sgn),
    .quo (quo),
    .rem (rem),
    .dz  (dz)
  );

  always_comb begin
    mul_sgn = 1'b0;
    is_div  = 1'b0;
    div_sgn = 1'b0;
    acc_add = 1'b0;
    acc_sub = 1'b0;
    case (in_op)
      OP_MULT:  mul_sgn = 1'b1;
      OP_DIV:   begin is_div = 1'b1; div_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin mul_sgn = 1'b1; acc_add = 1'b1; end
      OP_MADDU: acc_add = 1'b1;
      OP_MSUB:  begin mul_sgn = 1'b1; acc_sub = 1'b1; end
      OP_MSUBU: acc_sub = 1'b1;
`endif
      default: ;
    endcase

    mul_a = {{32{mul_sgn & in_a[31]}}, in_a};
    mul_b = {{32{mul_sgn & in_b[31]}}, in_b};
    prod  = mul_a * mul_b;
    sum   = acc_add ? ({hi_q, lo_q} + prod) :
            acc_sub ? ({hi_q, lo_q} - prod) : prod;

    res_hi_d = is_div ? rem : sum[63:32];
    res_lo_d = is_div ? quo : sum[31:0];
    cnt_load = is_div ? 4'(DIV_CYCLES - 1) : 4'(MUL_CYCLES - 1);

    accept  = is_multi(in_op) && (state_q == S_IDLE);
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q    <= cnt_load;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= !(is_div && dz);
          end else if (in_op == OP_MTHI) begin
            hi_q <= in_a;
          end else if (in_op == OP_MTLO) begin
            lo_q <= in_a;
          end
        end
        S_RUN: begin
          if (cnt_q == 4'd0) begin
            if (res_wr_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_start = accept;
  assign out_busy  = (state_q == S_RUN);
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign out_rdata = (state_q != S_IDLE) ? 32'd0 :
                     (in_op == OP_MFHI)  ? hi_q  :
                     (in_op == OP_MFLO)  ? lo_q  : 32'd0;

endmodule
